// File: rtl/nios2_system_loader_pkg.sv
// Shared types and constants for the on-chip memory boot loader.
// ONCHIP_LOADER_CHECKSUM_EN adds the CHECK state.
package nios2_system_loader_pkg;

  localparam int LANES  = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
`ifdef ONCHIP_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_e;

endpackage

// File: rtl/nios2_system_loader_packer.sv
// Little-endian byte-to-word packer for the boot loader.
// Exposes the word as it will look after this cycle's push.
module nios2_system_loader_packer
  import nios2_system_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    push,
  input  logic [BYTE_W-1:0]       byte_in,
  output logic                    full,
  output logic [LANES*BYTE_W-1:0] data_nx,
  output logic [LANES-1:0]        be_nx
);

  localparam int LW = $clog2(LANES);

  logic [LW-1:0]           lane_q;
  logic [LANES*BYTE_W-1:0] data_q;
  logic [LANES-1:0]        be_q;

  // high when a push this cycle fills the top lane
  assign full = (lane_q == LW'(LANES - 1));

  always_comb begin
    data_nx = data_q;
    be_nx   = be_q;
    if (push) begin
      data_nx[lane_q*BYTE_W +: BYTE_W] = byte_in;
      be_nx[lane_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      data_q <= '0;
      be_q   <= '0;
    end else if (clear) begin
      lane_q <= '0;
      data_q <= '0;
      be_q   <= '0;
    end else if (push) begin
      lane_q <= lane_q + 1'b1;
      data_q <= data_nx;
      be_q   <= be_nx;
    end
  end

endmodule

// File: rtl/nios2_system_onchip_memory_loader.sv
// Boot loader: byte stream -> sequential 32-bit writes, CPU held in reset.
// Define ONCHIP_LOADER_CHECKSUM_EN for a trailing checksum byte.
module nios2_system_onchip_memory_loader
  import nios2_system_loader_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int LEN_W  = ADDR_W + 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  length,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              cpu_reset_req,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_e state_q, state_d;

  logic [LEN_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              acc, go, last;
  logic              rdy_d, wr_d;
  logic              pk_full, pk_push, pk_clear;
  logic [31:0]       pk_data;
  logic [3:0]        pk_be;

  assign acc      = s_valid & s_ready;
  assign go       = start & (state_q == S_IDLE);
  assign last     = (cnt_q == LEN_W'(1));
  assign pk_push  = acc & (state_q == S_COLLECT);
  assign pk_clear = go | (state_q == S_WRITE);

  nios2_system_loader_packer u_packer (
    .clk     (clk),
    .rst_n   (reset_n),
    .clear   (pk_clear),
    .push    (pk_push),
    .byte_in (s_data),
    .full    (pk_full),
    .data_nx (pk_data),
    .be_nx   (pk_be)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (go)
          state_d = (length == '0) ? S_DONE : S_COLLECT;
      S_COLLECT:
        if (pk_push && (pk_full || last))
          state_d = S_WRITE;
      S_WRITE:
        if (cnt_q != '0)
          state_d = S_COLLECT;
        else
`ifdef ONCHIP_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
      S_CHECK:
        if (acc)
          state_d = S_DONE;
`else
          state_d = S_DONE;
`endif
      S_DONE:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // outputs are registered from the next state
  always_comb begin
    rdy_d = (state_d == S_COLLECT);
`ifdef ONCHIP_LOADER_CHECKSUM_EN
    rdy_d = rdy_d | (state_d == S_CHECK);
`endif
    wr_d  = (state_d == S_WRITE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      addr_q         <= '0;
      s_ready        <= 1'b0;
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
      cpu_reset_req  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state_q        <= state_d;
      s_ready        <= rdy_d;
      busy           <= (state_d != S_IDLE);
      cpu_reset_req  <= (state_d != S_IDLE);
      done           <= (state_d == S_DONE);
      mem_write      <= wr_d;
      mem_chipselect <= wr_d;
      mem_byteenable <= wr_d ? pk_be : 4'h0;
      if (wr_d) begin
        mem_address   <= addr_q;
        mem_writedata <= pk_data;
      end
      if (go) begin
        cnt_q  <= length;
        addr_q <= '0;
      end else begin
        if (pk_push)
          cnt_q <= cnt_q - 1'b1;
        if (state_q == S_WRITE)
          addr_q <= addr_q + 1'b1;
      end
    end
  end

`ifdef ONCHIP_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
      error <= 1'b0;
    end else if (go) begin
      sum_q <= '0;
      error <= 1'b0;
    end else begin
      if (pk_push)
        sum_q <= sum_q + s_data;
      if (acc && state_q == S_CHECK)
        error <= ((sum_q + s_data) != 8'd0);
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: doc/nios2_system_onchip_memory_loader.md
# nios2_system_onchip_memory_loader

Boot-time loader that sits directly upstream of the 8192×32 single-port on-chip memory. Consumes a byte stream (UART/JTAG receiver), packs bytes little-endian into 32-bit words, and writes them sequentially from word 0 through the memory's write port. Holds the CPU in reset for the whole load. Releases it with a one-cycle `done` pulse.

## Interface
Parameters:
- `ADDR_W`, 13, memory word-address width.
- `LEN_W`, `ADDR_W+2`, byte-length width; maximum load is 2^LEN_W−1 bytes.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle start pulse; ignored unless idle.
- `length`  in  LEN_W  byte count, sampled on accepted `start`.
- `s_valid`  in  1  byte stream valid.
- `s_data`  in  8  byte stream data.
- `s_ready`  out  1  loader accepts a byte this cycle.
- `mem_address`  out  ADDR_W  word address.
- `mem_byteenable`  out  4  byte lanes written.
- `mem_chipselect`  out  1  write strobe qualifier.
- `mem_write`  out  1  write strobe.
- `mem_writedata`  out  32  packed word.
- `cpu_reset_req`  out  1  holds the CPU in reset while loading.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  sticky checksum failure; cleared on the next accepted `start`.

## Operation
- States: IDLE, COLLECT, WRITE, CHECK (macro only), DONE.
- **IDLE:**
  - `start` latches `length` into a byte counter and clears word address, lane index, data register and `error`.
  - If `length`=0, go to DONE; otherwise go to COLLECT.
- **COLLECT:**
  - `s_ready`=1. A byte is accepted on `s_valid & s_ready`.
  - Byte k of a word goes to lane k (`mem_writedata[8k+7:8k]`); its `mem_byteenable` bit is set.
  - Move to WRITE after lane 3 is filled or after the final byte of `length`.
- **WRITE:**
  - Exactly one cycle with `mem_chipselect`=`mem_write`=1 and `s_ready`=0.
  - Address is the current word index. Partial final words enable only the filled lanes.
  - The address then increments. Go to COLLECT if bytes remain; otherwise go to CHECK (macro) or DONE.
- **DONE:** `done`=1 for one cycle, then IDLE.
- `cpu_reset_req`=1 from the cycle after an accepted `start` through the DONE cycle inclusive.
- Word address never wraps: `LEN_W` bounds the load to the memory capacity.
- `start` while busy is ignored and has no effect on the counters.
- Outside WRITE: `mem_write`, `mem_chipselect` and `mem_byteenable` are 0. `mem_address` and `mem_writedata` hold their values.

## Timing
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - `cpu_reset_req` is 0: a system reset already resets the CPU.
- Reset mid-load aborts immediately. No further memory writes occur, and memory contents are left partially written.
- Full rate: 4 accept cycles plus 1 write cycle per word, i.e. 5 cycles/word.
- Latency: last byte accepted at cycle N → write at N+1 → `done` at N+2 (no macro) or after the checksum byte (with macro).
- Stream stalls (`s_valid`=0) hold the state, with no timeout.
- All outputs are registered.

## Configuration
- Macro `ONCHIP_LOADER_CHECKSUM_EN`.
- **Defined:**
  - After the last write the loader enters CHECK with `s_ready`=1 and accepts one extra checksum byte.
  - `error` is set if the 8-bit sum of all payload bytes plus the checksum byte is not 0.
  - DONE still follows. Memory writes are unaffected.
- **Undefined:** CHECK and the sum register are absent, and `error` is tied to 0.

## Structure
- Package `nios2_system_loader_pkg` holds:
  - the state enum;
  - `LANES`=4;
  - the `BYTE_W`=8 constant.
- One sub-module, `nios2_system_loader_packer`, is natural. It holds the lane index, data register and byteenable accumulation, with `clear`/`push`/`full` controls. The FSM, counters and checksum stay in the top.

## Test plan
- **Aligned load:** `length`=8, bytes 0x11..0x18 at full rate → writes addr0 0x14131211 with be 0xF, then addr1 0x18171615 with be 0xF; `done` pulses 2 cycles after the last byte; `cpu_reset_req` is high throughout.
- **Partial word:** `length`=6, bytes 0xA0..0xA5 → second write is addr1, `mem_writedata[15:0]`=0xA5A4, be 0x3.
- **Zero length:** `length`=0 → no write; `done` the cycle after IDLE exits; `busy` is high for 1 cycle.
- **Stalls plus start while busy:** `s_valid` toggles 1/0; a second `start` with `length`=100 mid-load → original length honoured and data order intact.
- **Reset mid-load:** assert `reset_n`=0 after 5 of 12 bytes → all outputs go to 0 immediately and no further writes occur. A fresh `start` then restarts at addr0.
- **Checksum (macro defined):** bytes 0x01,0x02,0x03,0x04 plus checksum 0xF6 → `error`=0. With checksum 0xF5 → `error`=1 and held until the next `start`. In both cases addr0 = 0x04030201.
